// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared encodings for the fetch front end
// Contents: memory command codes, FSM state encoding, pc_sel codes, branch condition codes.
package fetch_pkg;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'b00,
    CMD_READ  = 2'b01,
    CMD_WRITE = 2'b10
  } mem_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_DATA  = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    PC_RESET  = 2'b00,
    PC_INC    = 2'b01,
    PC_BRANCH = 2'b10,
    PC_TARGET = 2'b11
  } pc_sel_e;

  typedef enum logic [2:0] {
    COND_AL = 3'b000,
    COND_EQ = 3'b001,
    COND_NE = 3'b010,
    COND_LT = 3'b011,
    COND_LE = 3'b100
  } cond_e;

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - branch condition evaluator
// Ports: cond (condition code), n/v/z (status flags) -> taken (combinational result).
// Codes 101..111 are reserved and never take the branch.
module cond_eval
  import fetch_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       n,
  input  logic       v,
  input  logic       z,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_AL: taken = 1'b1;
      COND_EQ: taken = z;
      COND_NE: taken = ~z;
      COND_LT: taken = n ^ v;
      COND_LE: taken = (n ^ v) | z;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch / data access front end with ready-handshake memory port
// Inputs:  clk, reset (sync, active low), fetch_req, data_req, data_we, pc_load, pc_sel, offset,
//          target, cond, N, V, Z, daddr_load, mem_rdata, mem_ready.
// Outputs: mem_cmd, mem_addr, pc, ir, fetch_done, data_done, busy, taken, stall_cnt.
// Build option: FETCH_STALL_CNT_EN builds the saturating wait-state counter; otherwise stall_cnt is 0.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          AW        = 9,
  parameter int          IW        = 16,
  parameter int          OFFW      = 8,
  parameter int unsigned RESET_VEC = 0,
  parameter int          CNTW      = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_req,
  input  logic            data_req,
  input  logic            data_we,
  input  logic            pc_load,
  input  logic [1:0]      pc_sel,
  input  logic [OFFW-1:0] offset,
  input  logic [AW-1:0]   target,
  input  logic [2:0]      cond,
  input  logic            N,
  input  logic            V,
  input  logic            Z,
  input  logic            daddr_load,
  input  logic [IW-1:0]   mem_rdata,
  input  logic            mem_ready,
  output logic [1:0]      mem_cmd,
  output logic [AW-1:0]   mem_addr,
  output logic [AW-1:0]   pc,
  output logic [IW-1:0]   ir,
  output logic            fetch_done,
  output logic            data_done,
  output logic            busy,
  output logic            taken,
  output logic [CNTW-1:0] stall_cnt
);

  state_e        state, state_next;
  logic [AW-1:0] daddr;
  logic          we_latched;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] off_ext;
  logic [AW-1:0] pc_next;

  cond_eval u_cond_eval (
    .cond  (cond),
    .n     (N),
    .v     (V),
    .z     (Z),
    .taken (taken)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // mem_cmd/mem_addr depend only on state and registers, so mem_ready never reaches them.
  always_comb begin
    state_next = state;
    mem_cmd    = CMD_NONE;
    mem_addr   = pc;
    busy       = 1'b0;
    case (state)
      ST_IDLE: begin
        // Data wins; the controller keeps a losing fetch_req asserted.
        if (data_req)       state_next = ST_DATA;
        else if (fetch_req) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        mem_cmd  = CMD_READ;
        mem_addr = pc;
        busy     = 1'b1;
        if (mem_ready) state_next = ST_IDLE;
      end
      ST_DATA: begin
        mem_cmd  = we_latched ? CMD_WRITE : CMD_READ;
        mem_addr = daddr;
        busy     = 1'b1;
        if (mem_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // All PC sums wrap modulo 2^AW; the offset is sign-extended to AW first.
  assign pc_inc  = pc + AW'(1);
  assign off_ext = AW'($signed(offset));

  always_comb begin
    pc_next = pc;
    case (pc_sel)
      PC_RESET:  pc_next = AW'(RESET_VEC);
      PC_INC:    pc_next = pc_inc;
      PC_BRANCH: pc_next = taken ? (pc_inc + off_ext) : pc_inc;
      PC_TARGET: pc_next = target;
      default:   pc_next = pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc         <= AW'(RESET_VEC);
      ir         <= '0;
      daddr      <= '0;
      we_latched <= 1'b0;
      fetch_done <= 1'b0;
      data_done  <= 1'b0;
    end else begin
      fetch_done <= (state == ST_FETCH) && mem_ready;
      data_done  <= (state == ST_DATA) && mem_ready;
      if ((state == ST_FETCH) && mem_ready) ir <= mem_rdata;
      if ((state == ST_IDLE) && data_req)   we_latched <= data_we;
      if (daddr_load)                       daddr <= target;
      // PC must stay stable while a fetch is outstanding, so loads outside IDLE are dropped.
      if ((state == ST_IDLE) && pc_load)    pc <= pc_next;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [CNTW-1:0] stall_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_reg <= '0;
    end else if ((state != ST_IDLE) && !mem_ready && (stall_reg != {CNTW{1'b1}})) begin
      stall_reg <= stall_reg + CNTW'(1);
    end
  end

  assign stall_cnt = stall_reg;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a behavioural PC/branch model
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req, data_req, data_we, pc_load;
  logic [1:0]  pc_sel;
  logic [7:0]  offset;
  logic [8:0]  target;
  logic [2:0]  cond;
  logic        N, V, Z;
  logic        daddr_load;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [8:0]  pc;
  logic [15:0] ir;
  logic        fetch_done, data_done, busy, taken;
  logic [15:0] stall_cnt;

  fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_req  (fetch_req),
    .data_req   (data_req),
    .data_we    (data_we),
    .pc_load    (pc_load),
    .pc_sel     (pc_sel),
    .offset     (offset),
    .target     (target),
    .cond       (cond),
    .N          (N),
    .V          (V),
    .Z          (Z),
    .daddr_load (daddr_load),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .pc         (pc),
    .ir         (ir),
    .fetch_done (fetch_done),
    .data_done  (data_done),
    .busy       (busy),
    .taken      (taken),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_data;
    logic [15:0] ir;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state
  int          m_pc = 0;
  int          m_stall = 0;
  logic [15:0] m_ir = 16'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic bit ref_taken(input int c, input bit n, input bit v, input bit z);
    if (c == 0) return 1'b1;
    if (c == 1) return z;
    if (c == 2) return !z;
    if (c == 3) return n != v;
    if (c == 4) return (n != v) || z;
    return 1'b0;
  endfunction

  function automatic int exp_stall();
`ifdef FETCH_STALL_CNT_EN
    return m_stall;
`else
    return 0;
`endif
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (fetch_done || data_done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: fetch_done=%0d data_done=%0d required none", fetch_done, data_done);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ((data_done !== e.is_data) || (fetch_done !== !e.is_data) ||
            (!e.is_data && ir !== e.ir)) begin
          errors++;
          $display("FAIL sb_done: fetch_done=%0d data_done=%0d ir=%h required data=%0d ir=%h",
                   fetch_done, data_done, ir, e.is_data, e.ir);
        end
      end
    end
  end

  task automatic wait_access(input int stalls, input logic [1:0] cmd, input logic [8:0] addr,
                             input bit try_pcload);
    int busy_cnt = 0;
    mem_ready = (stalls == 0);
    for (int i = 0; i <= stalls; i++) begin
      pc_load = try_pcload;
      pc_sel  = 2'b01;
      @(negedge clk);
      chk("acc_cmd", mem_cmd, cmd);
      chk("acc_addr", mem_addr, addr);
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      mem_ready = ((i + 1) == stalls);
    end
    pc_load = 1'b0;
    m_stall = (m_stall + stalls > 65535) ? 65535 : m_stall + stalls;
    @(negedge clk);
    chk("acc_busy_cycles", busy_cnt, stalls + 1);
    chk("done_idle", busy, 0);
    chk("pc_stable", pc, m_pc);
    chk("stall_cnt", stall_cnt, exp_stall());
    #1 chk("sb_drain", sb.size(), 0);
  endtask

  task automatic do_fetch(input int stalls, input logic [15:0] d, input bit try_pcload);
    fetch_req = 1'b1;
    @(posedge clk); #1;
    fetch_req = 1'b0;
    mem_rdata = d;
    sb.push_back('{is_data: 1'b0, ir: d});
    m_ir = d;
    wait_access(stalls, 2'b01, m_pc[8:0], try_pcload);
    chk("ir", ir, m_ir);
  endtask

  task automatic do_data(input bit we, input logic [8:0] a, input int stalls, input bit keep_fetch);
    daddr_load = 1'b1;
    target     = a;
    @(posedge clk); #1;
    daddr_load = 1'b0;
    target     = 9'($urandom);
    data_req   = 1'b1;
    data_we    = we;
    fetch_req  = keep_fetch;
    @(posedge clk); #1;
    data_req   = 1'b0;
    data_we    = ~we;
    mem_rdata  = 16'($urandom);
    sb.push_back('{is_data: 1'b1, ir: 16'h0});
    wait_access(stalls, we ? 2'b10 : 2'b01, a, 1'b0);
  endtask

  task automatic do_pc(input logic [1:0] sel, input logic [7:0] off, input logic [2:0] c,
                       input bit n, input bit v, input bit z, input logic [8:0] tgt);
    bit tk;
    int off_int;
    pc_load = 1'b1;
    pc_sel  = sel;
    offset  = off;
    cond    = c;
    N = n; V = v; Z = z;
    target  = tgt;
    #1;
    tk = ref_taken(int'(c), n, v, z);
    chk("taken", taken, tk);
    @(posedge clk); #1;
    pc_load = 1'b0;
    off_int = $signed(off);
    case (sel)
      2'b00: m_pc = 0;
      2'b01: m_pc = (m_pc + 1) & 511;
      2'b10: m_pc = (m_pc + 1 + (tk ? off_int : 0)) & 511;
      default: m_pc = int'(tgt);
    endcase
    @(negedge clk);
    chk("pc_after_load", pc, m_pc);
  endtask

  task automatic do_reset_mid_fetch();
    fetch_req = 1'b1;
    @(posedge clk); #1;
    fetch_req = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("rst_pre_cmd", mem_cmd, 2'b01);
    @(posedge clk); #1;
    reset     = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 16'hDEAD;
    @(posedge clk); #1;
    reset     = 1'b1;
    mem_ready = 1'b0;
    m_pc = 0; m_stall = 0; m_ir = 16'h0;
    @(negedge clk);
    chk("rst_cmd", mem_cmd, 2'b00);
    chk("rst_pc", pc, 0);
    chk("rst_ir", ir, 16'h0);
    chk("rst_fetch_done", fetch_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall_cnt, 0);
    @(negedge clk);
    chk("rst_no_late_done", fetch_done, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    fetch_req = 0; data_req = 0; data_we = 0; pc_load = 0; pc_sel = 0;
    offset = 0; target = 0; cond = 0; N = 0; V = 0; Z = 0;
    daddr_load = 0; mem_rdata = 0; mem_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_pc", pc, 0);
    chk("reset_ir", ir, 0);
    chk("reset_cmd", mem_cmd, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", {fetch_done, data_done}, 0);
    chk("reset_stall", stall_cnt, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Zero-wait fetch at the reset vector.
    do_fetch(0, 16'hA5C3, 1'b0);
    chk("first_ir", ir, 16'hA5C3);
    // Three wait states.
    do_fetch(3, 16'h1234, 1'b0);

    // Branch taken / not taken with a negative offset.
    do_pc(2'b11, 8'h00, 3'b000, 0, 0, 0, 9'h010);
    do_pc(2'b10, 8'hFE, 3'b001, 0, 0, 1, 9'h000);
    chk("branch_taken_pc", pc, 9'h00F);
    do_pc(2'b11, 8'h00, 3'b000, 0, 0, 0, 9'h010);
    do_pc(2'b10, 8'hFE, 3'b001, 0, 0, 0, 9'h000);
    chk("branch_not_taken_pc", pc, 9'h011);

    // PC wrap and pc_load dropped during FETCH.
    do_pc(2'b11, 8'h00, 3'b000, 0, 0, 0, 9'h1FF);
    do_pc(2'b01, 8'h00, 3'b000, 0, 0, 0, 9'h000);
    chk("pc_wrap", pc, 9'h000);
    do_fetch(2, 16'h0F0F, 1'b1);

    // Simultaneous requests: data write first, then the held fetch.
    do_data(1'b1, 9'h040, 1, 1'b1);
    do_fetch(0, 16'hBEEF, 1'b0);

    do_reset_mid_fetch();

    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0: do_fetch($urandom_range(0, 3), 16'($urandom), 1'($urandom));
        1: do_data(1'($urandom), 9'($urandom), $urandom_range(0, 3), 1'b0);
        2: do_pc(2'($urandom), 8'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 9'($urandom));
        default: begin
          do_data(1'($urandom), 9'($urandom), $urandom_range(0, 3), 1'b1);
          do_fetch($urandom_range(0, 3), 16'($urandom), 1'b0);
        end
      endcase
    end

    repeat (2) @(posedge clk);
    #1 chk("final_sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
